// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   On-chip checker for a divided clock. div_clk is sampled on both edges of
//   clk, so each clk cycle yields two half-cycle samples: 'a' (taken at the
//   negedge) and 'b' (taken at the posedge). The pair is registered at one
//   posedge and processed at the next posedge. Period and high time are
//   measured in clk half-cycles and compared against the expected values.
//
// Ports
//   clk         source clock, both edges used for sampling
//   reset       synchronous active-high reset
//   div_clk     divided clock under test, synchronous to clk
//   enable      1 = monitor runs, 0 = measurement state cleared
//   err_clr     one-cycle pulse that clears err (a new error wins)
//   period_hc   last measured period, in half-cycles
//   high_hc     last measured high time, in half-cycles
//   meas_valid  one-cycle pulse when period_hc/high_hc update
//   locked      LOCK_COUNT consecutive matching measurements seen
//   err         sticky mismatch / timeout flag
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 6,
  parameter int EXP_HIGH   = 3,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk,
  input  logic             enable,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_hc,
  output logic [CNT_W-1:0] high_hc,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam int               MC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP_P    = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
  localparam logic [MC_W-1:0]  LOCK_LIM = MC_W'(LOCK_COUNT);

  // Sample capture
  logic s_neg_reg;
  logic pair_a_reg, pair_b_reg, pair_vld_reg;

  // Measurement state
  logic             prev_b_reg, prev_b_next;
  logic             hist_vld_reg, hist_vld_next;
  logic             armed_reg, armed_next;
  logic [CNT_W-1:0] hc_cnt_reg, hc_cnt_next;
  logic [CNT_W-1:0] hi_len_reg, hi_len_next;
  logic             fall_seen_reg, fall_seen_next;
  logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;

  // Output next-state
  logic [CNT_W-1:0] period_next, high_next;
  logic             meas_next, locked_next, err_next;

  // Negedge half of the sample stream.
  always_ff @(negedge clk) begin
    if (reset) s_neg_reg <= 1'b0;
    else       s_neg_reg <= div_clk;
  end

  // Pair capture. pair_vld marks pairs that were taken while enabled, so a
  // pair captured while disabled is never processed after re-enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_a_reg   <= 1'b0;
      pair_b_reg   <= 1'b0;
      pair_vld_reg <= 1'b0;
    end else begin
      pair_a_reg   <= s_neg_reg;
      pair_b_reg   <= div_clk;
      pair_vld_reg <= enable;
    end
  end

  always_comb begin
    logic             prev_s, cur_s;
    logic             tout, meas, is_match;
    logic [CNT_W-1:0] per_v, hi_v;
    logic             err_set;

    prev_b_next    = prev_b_reg;
    hist_vld_next  = hist_vld_reg;
    armed_next     = armed_reg;
    hc_cnt_next    = hc_cnt_reg;
    hi_len_next    = hi_len_reg;
    fall_seen_next = fall_seen_reg;
    match_cnt_next = match_cnt_reg;
    period_next    = period_hc;
    high_next      = high_hc;
    meas_next      = 1'b0;
    locked_next    = locked;
    err_set        = 1'b0;
    tout           = 1'b0;
    meas           = 1'b0;
    is_match       = 1'b0;
    per_v          = period_hc;
    hi_v           = high_hc;
    cur_s          = 1'b0;
    // Without a valid previous sample there is no edge into 'a'.
    prev_s         = hist_vld_reg ? prev_b_reg : pair_a_reg;

    if (!enable) begin
      prev_b_next    = 1'b0;
      hist_vld_next  = 1'b0;
      armed_next     = 1'b0;
      hc_cnt_next    = '0;
      hi_len_next    = '0;
      fall_seen_next = 1'b0;
      match_cnt_next = '0;
      locked_next    = 1'b0;
    end else if (pair_vld_reg) begin
      // Walk the two samples in time order: a, then b.
      for (int i = 0; i < 2; i++) begin
        cur_s = (i == 0) ? pair_a_reg : pair_b_reg;
        if (!prev_s && cur_s) begin
          if (armed_next) begin
            meas  = 1'b1;
            per_v = hc_cnt_next;
            hi_v  = fall_seen_next ? hi_len_next : hc_cnt_next;
          end
          armed_next     = 1'b1;
          hc_cnt_next    = CNT_W'(1);
          fall_seen_next = 1'b0;
        end else if (armed_next) begin
          if (prev_s && !cur_s) begin
            hi_len_next    = hc_cnt_next;
            fall_seen_next = 1'b1;
          end
          // Saturating count; the step into saturation is the timeout.
          if (hc_cnt_next != CNT_MAX) begin
            hc_cnt_next = hc_cnt_next + CNT_W'(1);
            if (hc_cnt_next == CNT_MAX) tout = 1'b1;
          end
        end
        prev_s = cur_s;
      end
      prev_b_next   = pair_b_reg;
      hist_vld_next = 1'b1;

      // A timeout can only precede a rise within one pair, so apply it first.
      if (tout) begin
        match_cnt_next = '0;
        locked_next    = 1'b0;
        err_set        = 1'b1;
      end
      if (meas) begin
        meas_next   = 1'b1;
        period_next = per_v;
        high_next   = hi_v;
        is_match    = (per_v == EXP_P) && (hi_v == EXP_H);
        if (is_match) begin
          if (match_cnt_next != LOCK_LIM) match_cnt_next = match_cnt_next + MC_W'(1);
          locked_next = (match_cnt_next == LOCK_LIM);
        end else begin
          match_cnt_next = '0;
          locked_next    = 1'b0;
          err_set        = 1'b1;
        end
      end
    end

    err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_b_reg    <= 1'b0;
      hist_vld_reg  <= 1'b0;
      armed_reg     <= 1'b0;
      hc_cnt_reg    <= '0;
      hi_len_reg    <= '0;
      fall_seen_reg <= 1'b0;
      match_cnt_reg <= '0;
      period_hc     <= '0;
      high_hc       <= '0;
      meas_valid    <= 1'b0;
      locked        <= 1'b0;
      err           <= 1'b0;
    end else begin
      prev_b_reg    <= prev_b_next;
      hist_vld_reg  <= hist_vld_next;
      armed_reg     <= armed_next;
      hc_cnt_reg    <= hc_cnt_next;
      hi_len_reg    <= hi_len_next;
      fall_seen_reg <= fall_seen_next;
      match_cnt_reg <= match_cnt_next;
      period_hc     <= period_next;
      high_hc       <= high_next;
      meas_valid    <= meas_next;
      locked        <= locked_next;
      err           <= err_next;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: directed phases plus a randomized phase,
// checked every cycle against a sample-stream reference model.
module tb_clk_div_monitor;

  localparam int SAT   = 255;
  localparam int EXP_P = 6;
  localparam int EXP_H = 3;
  localparam int LOCKN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       div_clk = 1'b0;
  logic       enable = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] period_hc, high_hc;
  logic       meas_valid, locked, err;

  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .LOCK_COUNT(LOCKN)) dut (
    .clk(clk), .reset(reset), .div_clk(div_clk), .enable(enable), .err_clr(err_clr),
    .period_hc(period_hc), .high_hc(high_hc), .meas_valid(meas_valid),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit smp_q[$];

  // Reference model: indices of samples since the monitoring epoch began.
  bit m_have_prev, m_prev, m_armed, m_fall_seen, m_locked, m_err, m_mvalid, m_eset;
  int m_idx, m_last_rise, m_fall_len, m_match, m_period, m_high;
  bit pend_vld, pend_a, pend_b;
  bit clr_on_meas = 1'b0;

  // Bookkeeping on observed DUT behaviour for the directed checks.
  int dv_cnt, lock_at, first_per;

  function automatic int sat(int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, int exp);
    tests++;
    assert (obs === 32'(exp))
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_epoch_clear();
    m_have_prev = 0; m_prev = 0; m_armed = 0; m_fall_seen = 0;
    m_idx = 0; m_last_rise = 0; m_match = 0; m_locked = 0;
  endtask

  task automatic model_sample(bit s);
    if (m_have_prev && !m_prev && s) begin
      if (m_armed) begin
        m_period = sat(m_idx - m_last_rise);
        m_high   = m_fall_seen ? m_fall_len : m_period;
        m_mvalid = 1;
        if (m_period == EXP_P && m_high == EXP_H) begin
          if (m_match < LOCKN) m_match++;
          m_locked = (m_match >= LOCKN);
        end else begin
          m_match = 0; m_locked = 0; m_eset = 1;
        end
      end
      m_armed = 1; m_last_rise = m_idx; m_fall_seen = 0;
    end else if (m_armed) begin
      if (m_prev && !s) begin
        m_fall_len  = sat(m_idx - m_last_rise);
        m_fall_seen = 1;
      end
      if (m_idx - m_last_rise + 1 == SAT) begin
        m_match = 0; m_locked = 0; m_eset = 1;
      end
    end
    m_prev = s; m_have_prev = 1; m_idx++;
  endtask

  task automatic push(int hi, int lo, int reps);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < hi; k++) smp_q.push_back(1'b1);
      for (int k = 0; k < lo; k++) smp_q.push_back(1'b0);
    end
  endtask

  task automatic mark();
    dv_cnt = 0; lock_at = 0; first_per = -1;
  endtask

  // One clk cycle: drive two half-cycle samples, advance the model, check.
  task automatic cycle();
    bit va, vb;
    va = (smp_q.size() > 0) ? smp_q.pop_front() : div_clk;
    vb = (smp_q.size() > 0) ? smp_q.pop_front() : va;
    div_clk = va;
    @(negedge clk); #1;
    div_clk = vb;
    m_mvalid = 0; m_eset = 0;
    if (reset) begin
      model_epoch_clear();
      m_err = 0; m_period = 0; m_high = 0; pend_vld = 0;
    end else begin
      if (!enable) model_epoch_clear();
      else if (pend_vld) begin
        model_sample(pend_a);
        model_sample(pend_b);
      end
      if (clr_on_meas && m_mvalid && m_eset) err_clr = 1'b1;
      m_err = m_eset ? 1'b1 : (err_clr ? 1'b0 : m_err);
      pend_vld = enable; pend_a = va; pend_b = vb;
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("meas_valid", 32'(meas_valid), int'(m_mvalid));
    chk("period_hc", 32'(period_hc), m_period);
    chk("high_hc", 32'(high_hc), m_high);
    chk("locked", 32'(locked), int'(m_locked));
    chk("err", 32'(err), int'(m_err));
    if (meas_valid === 1'b1) begin
      dv_cnt++;
      if (first_per < 0) first_per = int'(period_hc);
      $display("[TB] meas period_hc=%0d high_hc=%0d locked=%0b err=%0b", period_hc, high_hc, locked, err);
    end
    if (locked === 1'b1 && lock_at == 0) lock_at = dv_cnt;
  endtask

  task automatic drain(bit rnd);
    while (smp_q.size() > 0) begin
      if (rnd) begin
        err_clr = ($urandom_range(0, 7) == 0);
        enable  = ($urandom_range(0, 40) != 0);
      end
      cycle();
    end
    enable = 1'b1;
  endtask

  initial begin
    m_err = 0; m_period = 0; m_high = 0; m_fall_len = 0; pend_vld = 0;
    model_epoch_clear();
    mark();
    @(posedge clk); #1;

    // Reset state
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_period", 32'(period_hc), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    enable = 1'b1;

    // 1: div-by-3 pattern locks at the 4th measurement
    mark();
    push(3, 3, 8); drain(0);
    chk("p1_lock_at_valid", 32'(lock_at), 4);
    chk("p1_locked", 32'(locked), 1);
    chk("p1_err", 32'(err), 0);
    chk("p1_period", 32'(period_hc), 6);
    chk("p1_high", 32'(high_hc), 3);

    // 2: switch to div-by-2 after lock
    push(2, 2, 6); drain(0);
    chk("p2_period", 32'(period_hc), 4);
    chk("p2_high", 32'(high_hc), 2);
    chk("p2_locked", 32'(locked), 0);
    chk("p2_err", 32'(err), 1);

    // 4: err_clr coinciding with a mismatch loses; a quiet err_clr wins
    clr_on_meas = 1'b1;
    push(2, 2, 3); drain(0);
    clr_on_meas = 1'b0;
    chk("p4_err_held", 32'(err), 1);
    push(3, 3, 4); drain(0);
    push(3, 3, 1);
    err_clr = 1'b1;
    cycle();
    drain(0);
    chk("p4_err_cleared", 32'(err), 0);

    // 3: div_clk stuck low -> timeout, then the next rise reports saturation
    push(3, 300, 1); drain(0);
    chk("p3_err", 32'(err), 1);
    chk("p3_locked", 32'(locked), 0);
    push(3, 3, 1); drain(0);
    chk("p3_period_sat", 32'(period_hc), 255);

    // 5: reset two cycles into a period
    push(3, 3, 6); drain(0);
    push(3, 1, 1); drain(0);
    reset = 1'b1;
    push(0, 2, 1); cycle(); cycle();
    reset = 1'b0;
    chk("p5_period0", 32'(period_hc), 0);
    chk("p5_high0", 32'(high_hc), 0);
    chk("p5_locked0", 32'(locked), 0);
    chk("p5_err0", 32'(err), 0);
    mark();
    push(3, 3, 4); drain(0);
    chk("p5_first_period", 32'(first_per), 6);

    // 6: enable dropped for 10 cycles, then relock
    push(3, 3, 4); drain(0);
    enable = 1'b0;
    push(3, 3, 4);
    cycle();
    chk("p6_locked_drop", 32'(locked), 0);
    chk("p6_period_hold", 32'(period_hc), 6);
    for (int i = 0; i < 9; i++) cycle();
    enable = 1'b1;
    smp_q.delete();
    mark();
    push(3, 3, 8); drain(0);
    chk("p6_relock_at_valid", 32'(lock_at), 4);

    // Randomized phase
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 2) == 0) push(3, 3, $urandom_range(1, 6));
      else push($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 4));
      drain(1);
    end
    push(3, 3, 2); drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
